ret_capture_buf: RTL and testbench

RET_CAPTURE_BUF -- requirements
Module: ret_capture_buf

---
 rtl/ret_capture_buf.sv | 258 +++++++++++++++++++++++++
 tb/tb_ret_capture_buf.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ret_capture_buf.sv
// ret_capture_buf: multi-channel return-data capture buffer.
// A start pulse opens a capture window (RUN). Each channel pushes
// {sample, per-channel index} into its own FIFO. A round-robin arbiter
// feeds a single registered output stage with valid/ready handshake.
// The window closes on stop or on the MAXCYC cycle limit. After that,
// the FIFOs drain (DRAIN), and the block reports DONE.
module ret_capture_buf #(
    parameter  int NCH    = 2,
    parameter  int DW     = 32,
    parameter  int DEPTH  = 16,
    parameter  int IDXW   = 16,
    parameter  int MAXCYC = 100000,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              start,
    input  logic              stop,
    input  logic [NCH*DW-1:0] ret_din,
    input  logic [NCH-1:0]    ret_vld,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [CHW-1:0]    out_ch,
    output logic [IDXW-1:0]   out_index,
    output logic [31:0]       cyc_cnt,
    output logic [NCH-1:0]    ovf,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DW + IDXW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;

    logic [31:0]                r_cyc;
    logic                       r_timeout;
    logic [NCH-1:0]             r_ovf;
    logic [NCH-1:0][IDXW-1:0]   r_idx;
    logic [NCH-1:0][AW:0]       r_wr_ptr;
    logic [NCH-1:0][AW:0]       r_rd_ptr;
    logic [EW-1:0]              r_mem [NCH][DEPTH];

    logic                       r_out_valid;
    logic [DW-1:0]              r_out_data;
    logic [CHW-1:0]             r_out_ch;
    logic [IDXW-1:0]            r_out_index;
    logic [CHW-1:0]             r_last;

    logic                       w_enter_run;
    logic                       w_term;
    logic [NCH-1:0]             w_empty;
    logic [NCH-1:0]             w_full;
    logic [NCH-1:0]             w_push_req;
    logic [NCH-1:0]             w_push;
    logic [NCH-1:0]             w_pop;
    logic [NCH-1:0]             w_drop;
    logic                       w_all_empty;
    logic                       w_any;
    logic                       w_load;
    logic                       w_found;
    logic [CHW-1:0]             w_grant;
    logic [CHW-1:0]             w_cand;
    logic [EW-1:0]              w_head;
    logic                       w_busy;
    logic                       w_done;

    // A window opens only from IDLE or DONE; start is ignored in RUN and DRAIN.
    assign w_enter_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // Terminal count: the last RUN cycle allowed by MAXCYC.
    assign w_term      = (r_state == ST_RUN) && (r_cyc == 32'(MAXCYC - 1));

    // FSM state register.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_RUN;
                else       w_next_state = ST_IDLE;
            end
            ST_RUN: begin
                if (stop || w_term) w_next_state = ST_DRAIN;
                else                w_next_state = ST_RUN;
            end
            ST_DRAIN: begin
                if (w_all_empty && !r_out_valid) w_next_state = ST_DONE;
                else                             w_next_state = ST_DRAIN;
            end
            ST_DONE: begin
                if (start) w_next_state = ST_RUN;
                else       w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_RUN:   w_busy = 1'b1;
            ST_DRAIN: w_busy = 1'b1;
            ST_DONE:  w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Per-channel FIFO status from the wrap-bit pointer pair.
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int c = 0; c < NCH; c++) begin
            w_empty[c] = (r_wr_ptr[c] == r_rd_ptr[c]);
            w_full[c]  = (r_wr_ptr[c][AW] != r_rd_ptr[c][AW]) &&
                         (r_wr_ptr[c][AW-1:0] == r_rd_ptr[c][AW-1:0]);
        end
    end

    assign w_all_empty = &w_empty;
    assign w_any       = ~w_all_empty;

    // Round-robin grant: search starts at the channel after the last grant.
    always_comb begin
        w_grant = r_last;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= NCH; i++) begin
            w_cand = ((int'(r_last) + i) >= NCH) ? CHW'(int'(r_last) + i - NCH)
                                                 : CHW'(int'(r_last) + i);
            if (!w_found && !w_empty[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // The output register loads whenever it is free or being consumed.
    assign w_load = (!r_out_valid || out_ready) && w_any;
    assign w_head = r_mem[w_grant][r_rd_ptr[w_grant][AW-1:0]];

    // Push/pop/drop decisions; a full FIFO popped this cycle still accepts.
    always_comb begin
        w_push_req = '0;
        w_pop      = '0;
        w_push     = '0;
        w_drop     = '0;
        for (int c = 0; c < NCH; c++) begin
            w_push_req[c] = (r_state == ST_RUN) && ret_vld[c];
            w_pop[c]      = w_load && (w_grant == CHW'(c));
            w_push[c]     = w_push_req[c] && (!w_full[c] || w_pop[c]);
            w_drop[c]     = w_push_req[c] && w_full[c] && !w_pop[c];
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset here.
    always_ff @(posedge CLOCK) begin
        for (int c = 0; c < NCH; c++) begin
            if (w_push[c]) begin
                r_mem[c][r_wr_ptr[c][AW-1:0]] <= {ret_din[c*DW +: DW], r_idx[c]};
            end
        end
    end

    // FIFO pointers, sample indices and sticky overflow flags.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_idx    <= '0;
            r_ovf    <= '0;
        end else if (w_enter_run) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_idx    <= '0;
            r_ovf    <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_push[c])     r_wr_ptr[c] <= r_wr_ptr[c] + {{AW{1'b0}}, 1'b1};
                if (w_pop[c])      r_rd_ptr[c] <= r_rd_ptr[c] + {{AW{1'b0}}, 1'b1};
                // Index advances even on a dropped sample so the gap is visible.
                if (w_push_req[c]) r_idx[c]    <= r_idx[c] + {{(IDXW-1){1'b0}}, 1'b1};
                if (w_drop[c])     r_ovf[c]    <= 1'b1;
            end
        end
    end

    // RUN cycle counter and sticky timeout flag.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_cyc     <= 32'd0;
            r_timeout <= 1'b0;
        end else if (w_enter_run) begin
            r_cyc     <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ST_RUN) r_cyc     <= r_cyc + 32'd1;
            if (w_term)            r_timeout <= 1'b1;
        end
    end

    // Output record register; fields hold while stalled by out_ready=0.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_index <= '0;
            r_last      <= CHW'(NCH - 1);
        end else if (w_enter_run) begin
            r_out_valid <= 1'b0;
            r_last      <= CHW'(NCH - 1);
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head[EW-1:IDXW];
            r_out_index <= w_head[IDXW-1:0];
            r_out_ch    <= w_grant;
            r_last      <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_index = r_out_index;
    assign cyc_cnt   = r_cyc;
    assign ovf       = r_ovf;
    assign timeout   = r_timeout;
    assign busy      = w_busy;
    assign done      = w_done;

endmodule

// File: tb/tb_ret_capture_buf.sv
// Directed testbench for ret_capture_buf (NCH=2, DEPTH=4, MAXCYC=8).
// Inputs change 1 time unit after a rising edge; outputs are checked at
// that same point, so each check sees the state left by the preceding edge.
module tb_ret_capture_buf;

    localparam int NCH    = 2;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int IDXW   = 16;
    localparam int MAXCYC = 8;

    logic              CLOCK = 1'b0;
    logic              RESET = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [NCH*DW-1:0] ret_din = '0;
    logic [NCH-1:0]    ret_vld = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [0:0]        out_ch;
    logic [IDXW-1:0]   out_index;
    logic [31:0]       cyc_cnt;
    logic [NCH-1:0]    ovf;
    logic              busy;
    logic              done;
    logic              timeout;

    int n_checks = 0;
    int n_errors = 0;

    ret_capture_buf #(
        .NCH(NCH), .DW(DW), .DEPTH(DEPTH), .IDXW(IDXW), .MAXCYC(MAXCYC)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .stop(stop),
        .ret_din(ret_din), .ret_vld(ret_vld),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_index(out_index), .cyc_cnt(cyc_cnt), .ovf(ovf),
        .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input int ch, input int idx, input int data);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_ch"},    64'(out_ch),    64'(ch));
        chk({tag, "_index"}, 64'(out_index), 64'(idx));
        chk({tag, "_data"},  64'(out_data),  64'(data));
    endtask

    // Safety net so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_cyc",   64'(cyc_cnt),   64'd0);
        chk("rst_ovf",   64'(ovf),       64'd0);
        chk("rst_tmo",   64'(timeout),   64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_index", 64'(out_index), 64'd0);
        RESET = 1'b1;
        tick();
        tick();
        chk("idle_hold_busy", 64'(busy), 64'd0);

        // ---------------- single channel, early stop ----------------
        out_ready = 1'b1;
        start = 1'b1;
        tick();                                   // E0: enter RUN
        start = 1'b0;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_cyc0", 64'(cyc_cnt), 64'd0);
        for (int k = 0; k < 5; k++) begin
            ret_vld = 2'b01;
            ret_din = {32'd0, 32'(10 + k)};
            tick();                               // E(k+1): push idx k
            if (k == 0) chk("t1_no_early_valid", 64'(out_valid), 64'd0);
            else        chk_rec("t1_rec", 0, k - 1, 10 + k - 1);
        end
        chk("t1_cyc5", 64'(cyc_cnt), 64'd5);
        ret_vld = 2'b00;
        stop = 1'b1;
        tick();                                   // E6: last record, RUN->DRAIN
        stop = 1'b0;
        chk_rec("t1_rec4", 0, 4, 14);
        chk("t1_drain_busy", 64'(busy), 64'd1);
        tick();                                   // E7: record consumed
        chk("t1_valid_off", 64'(out_valid), 64'd0);
        chk("t1_not_done_yet", 64'(done), 64'd0);
        tick();                                   // E8: DRAIN->DONE
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_idle_busy", 64'(busy), 64'd0);
        chk("t1_no_tmo", 64'(timeout), 64'd0);
        chk("t1_cyc_hold", 64'(cyc_cnt), 64'd6);

        // ---------------- round robin, ignored start, timeout ----------------
        start = 1'b1;
        tick();                                   // E0: DONE->RUN
        start = 1'b0;
        chk("t2_busy", 64'(busy), 64'd1);
        chk("t2_done_clr", 64'(done), 64'd0);
        chk("t2_cyc_clr", 64'(cyc_cnt), 64'd0);
        for (int k = 0; k < 4; k++) begin
            ret_vld = 2'b11;
            ret_din = {32'(200 + k), 32'(100 + k)};
            start = (k == 2);                     // start in RUN must be ignored
            tick();                               // E(k+1)
            if (k >= 1) chk_rec("t2_rec", (k - 1) % 2, (k - 1) / 2, ((k - 1) % 2 == 1 ? 200 : 100) + (k - 1) / 2);
        end
        ret_vld = 2'b00;
        start = 1'b0;
        for (int j = 3; j < 8; j++) begin
            tick();                               // E(j+2)
            chk_rec("t2_rec", j % 2, j / 2, (j % 2 == 1 ? 200 : 100) + j / 2);
            if (j == 5) chk("t2_cyc7", 64'(cyc_cnt), 64'd7);
            if (j == 6) begin
                chk("t2_tmo", 64'(timeout), 64'd1);
                chk("t2_drain_busy", 64'(busy), 64'd1);
                chk("t2_drain_notdone", 64'(done), 64'd0);
            end
        end
        tick();                                   // E10
        chk("t2_valid_off", 64'(out_valid), 64'd0);
        tick();                                   // E11
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_cyc_hold", 64'(cyc_cnt), 64'd8);

        // ---------------- overflow, backpressure, full+pop push ----------------
        // Output register takes idx0 at E2, so FIFO holds idx1..4; idx5 is dropped.
        out_ready = 1'b0;
        start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        chk("t3_ovf_clr", 64'(ovf), 64'd0);
        chk("t3_tmo_clr", 64'(timeout), 64'd0);
        for (int k = 0; k < 6; k++) begin
            ret_vld = 2'b01;
            ret_din = {32'd0, 32'(50 + k)};
            tick();                               // E(k+1)
            if (k >= 1) chk_rec("t3_stall", 0, 0, 50);
            if (k == 4) chk("t3_no_ovf_yet", 64'(ovf), 64'd0);
        end
        chk("t3_ovf", 64'(ovf), 64'b01);
        ret_din = {32'd0, 32'd56};                // idx6, pushed into full FIFO while popping
        out_ready = 1'b1;
        tick();                                   // E7
        ret_vld = 2'b00;
        chk_rec("t3_rec1", 0, 1, 51);
        tick();
        chk_rec("t3_rec2", 0, 2, 52);
        tick();
        chk_rec("t3_rec3", 0, 3, 53);
        tick();
        chk_rec("t3_rec4", 0, 4, 54);
        tick();
        chk_rec("t3_rec6", 0, 6, 56);
        tick();
        chk("t3_valid_off", 64'(out_valid), 64'd0);
        tick();
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_ovf_sticky", 64'(ovf), 64'b01);

        // ---------------- stop coincident with terminal count ----------------
        start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        chk("t4_ovf_clr", 64'(ovf), 64'd0);
        for (int k = 0; k < 7; k++) tick();       // E1..E7
        chk("t4_cyc7", 64'(cyc_cnt), 64'd7);
        chk("t4_no_tmo", 64'(timeout), 64'd0);
        stop = 1'b1;
        tick();                                   // E8
        stop = 1'b0;
        chk("t4_tmo", 64'(timeout), 64'd1);
        chk("t4_busy", 64'(busy), 64'd1);
        tick();
        chk("t4_done", 64'(done), 64'd1);

        // ---------------- asynchronous reset mid-RUN ----------------
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ret_vld = 2'b01;
            ret_din = {32'd0, 32'(30 + k)};
            tick();
        end
        ret_vld = 2'b00;
        chk("t5_pre_valid", 64'(out_valid), 64'd1);
        RESET = 1'b0;
        #1;
        chk("t5_async_valid", 64'(out_valid), 64'd0);
        chk("t5_async_busy",  64'(busy),      64'd0);
        chk("t5_async_cyc",   64'(cyc_cnt),   64'd0);
        chk("t5_async_data",  64'(out_data),  64'd0);
        tick();
        tick();
        RESET = 1'b1;
        tick();
        tick();
        chk("t5_idle_busy",  64'(busy),      64'd0);
        chk("t5_idle_done",  64'(done),      64'd0);
        chk("t5_idle_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        ret_vld = 2'b01;
        ret_din = {32'd0, 32'd77};
        tick();
        ret_vld = 2'b00;
        chk("t5_lat_valid", 64'(out_valid), 64'd0);
        tick();
        chk_rec("t5_rec", 0, 0, 77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
